alu_result_pipe_mux: RTL and testbench

ALU_RESULT_PIPE_MUX -- requirements
Module: alu_result_pipe_mux

---
 rtl/alu_mux_pkg.sv | 14 +
 rtl/alu_skid_buf.sv | 66 ++++++
 rtl/alu_result_pipe_mux.sv | 86 ++++++++
 tb/tb_alu_result_pipe_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mux_pkg.sv
// Shared types and constants for the ALU result pipeline mux and its skid buffer.
package alu_mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam int FLAG_NEG  = 1;
   localparam int FLAG_ZERO = 0;
   localparam int MAX_M     = 16;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry skid buffer: main register drives the outputs, skid register
// absorbs one beat of backpressure so in_ready depends only on registered state.
module alu_skid_buf
   import alu_mux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   skid_state_t  state, state_nxt;
   logic [W-1:0] main_q, skid_q;
   logic         acc, load_main, load_skid, main_from_skid;

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      acc            = in_valid && (state != FULL);
      case (state)
         EMPTY: if (acc) begin
            load_main = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: begin
            if (acc && out_ready) load_main = 1'b1;
            else if (acc) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (out_ready) state_nxt = EMPTY;
         end
         FULL: if (out_ready) begin
            main_from_skid = 1'b1;
            state_nxt      = BUSY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_main)           main_q <= in_data;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

   // Ready/valid are pure state decodes: no combinational out_ready -> in_ready path.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;

endmodule

// File: rtl/alu_result_pipe_mux.sv
// Selects one of M ALU results per beat and registers it through a skid buffer.
// Optional ALU_FLAGS_EN adds registered {neg, zero} flags carried with each beat.
module alu_result_pipe_mux
   import alu_mux_pkg::*;
#(
   parameter int N     = 32,
   parameter int M     = 8,
   parameter int SEL_W = $clog2(M)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [M-1:0][N-1:0] results,
   input  logic [SEL_W-1:0]    control,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [N-1:0]        out,
   output logic [SEL_W-1:0]    out_sel,
   output logic                out_err,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                err_clr,
   output logic                sticky_err
`ifdef ALU_FLAGS_EN
   ,
   output logic [1:0]          flags
`endif
);

`ifdef ALU_FLAGS_EN
   localparam int PW = N + SEL_W + 3;
`else
   localparam int PW = N + SEL_W + 1;
`endif

   logic [N-1:0]  sel_data;
   logic          in_range;
   logic [PW-1:0] pay_in, pay_out;

   // Out-of-range controls match no index, leaving data zero and in_range low.
   always_comb begin
      sel_data = '0;
      in_range = 1'b0;
      for (int k = 0; k < M; k++) begin
         if (control == SEL_W'(k)) begin
            sel_data = results[k];
            in_range = 1'b1;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic [1:0] flg_in;
   always_comb begin
      flg_in            = '0;
      flg_in[FLAG_NEG]  = sel_data[N-1];
      flg_in[FLAG_ZERO] = (sel_data == '0);
   end
   assign pay_in = {flg_in, ~in_range, control, sel_data};
   assign flags  = pay_out[N+SEL_W+2:N+SEL_W+1];
`else
   assign pay_in = {~in_range, control, sel_data};
`endif

   alu_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (pay_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (pay_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out     = pay_out[N-1:0];
   assign out_sel = pay_out[N+SEL_W-1:N];
   assign out_err = pay_out[N+SEL_W];

   // Set has priority over clear so a coincident bad beat is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              sticky_err <= 1'b0;
      else if (in_valid && in_ready && !in_range) sticky_err <= 1'b1;
      else if (err_clr)                        sticky_err <= 1'b0;
   end

endmodule

// File: tb/tb_alu_result_pipe_mux.sv
// Directed bench for alu_result_pipe_mux with a scoreboard queue of expected beats.
module tb_alu_result_pipe_mux;

   localparam int N = 32;
   localparam int M = 6;
   localparam int SW = 3;

   logic                clk, rst_n;
   logic [M-1:0][N-1:0] results;
   logic [SW-1:0]       control;
   logic                in_valid, in_ready, out_valid, out_ready, out_err;
   logic                err_clr, sticky_err;
   logic [N-1:0]        out;
   logic [SW-1:0]       out_sel;
`ifdef ALU_FLAGS_EN
   logic [1:0]          flags;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   int n_out = 0;
   int cyc   = 0;
   logic [N+SW:0] sbq[$];

   alu_result_pipe_mux #(.N(N), .M(M)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .results    (results),
      .control    (control),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out        (out),
      .out_sel    (out_sel),
      .out_err    (out_err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_clr    (err_clr),
      .sticky_err (sticky_err)
`ifdef ALU_FLAGS_EN
      ,
      .flags      (flags)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N+SW:0] expv(input logic [SW-1:0] c);
      if (int'(c) < M) return {1'b0, c, results[c]};
      return {1'b1, c, {N{1'b0}}};
   endfunction

   // Monitor: pops on every output transfer, pushes on every accepted input,
   // and checks outputs hold still across a stalled cycle.
   initial begin
      logic          stall_q;
      logic [N+SW:0] prev, e;
      stall_q = 1'b0;
      prev    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) stall_q = 1'b0;
         else begin
            if (stall_q) chk("stable", {out_err, out_sel, out}, prev);
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) chk("unexpected_out", sbq.size(), 1);
               else begin
                  e = sbq.pop_front();
                  chk("out_beat", {out_err, out_sel, out}, e);
                  n_out++;
               end
            end
            if (in_valid && in_ready) sbq.push_back(expv(control));
            stall_q = out_valid && !out_ready;
            prev    = {out_err, out_sel, out};
         end
      end
   end

   task automatic send(input logic [SW-1:0] c);
      int t;
      in_valid = 1'b1;
      control  = c;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_timeout", t, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 40) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain", sbq.size(), 0);
   endtask

   initial begin
      int n0, c0, t;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      control   = '0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      for (int k = 0; k < M; k++) results[k] = N'(k) * 32'h11111111;

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out", out, 0);
      chk("rst_sel_err", {out_sel, out_err}, 0);
      chk("rst_sticky", sticky_err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single beat, one-cycle latency, then back to empty
      send(3'd5);
      chk("lat_out", out, 32'h55555555);
      chk("lat_sel", out_sel, 5);
      chk("lat_valid", out_valid, 1);
      chk("lat_err", out_err, 0);
      @(posedge clk);
      #1;
      chk("empty_valid", out_valid, 0);
      chk("empty_ready", in_ready, 1);

      // out-of-range select and sticky error handling
      send(3'd7);
      chk("oor_out", out, 0);
      chk("oor_err", out_err, 1);
      chk("oor_sel", out_sel, 7);
      chk("oor_sticky", sticky_err, 1);
      @(posedge clk);
      #1;
      chk("sticky_hold", sticky_err, 1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("sticky_clr", sticky_err, 0);
      err_clr = 1'b1;
      send(3'd6);
      err_clr = 1'b0;
      chk("set_wins", sticky_err, 1);
      chk("oor6_err", out_err, 1);
      drain();

      // backpressure: two beats stored, third stalls
      out_ready = 1'b0;
      n0 = n_out;
      send(3'd1);
      send(3'd2);
      in_valid = 1'b1;
      control  = 3'd3;
      chk("full_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("full_hold_ready", in_ready, 0);
      chk("full_hold_out", out, 32'h11111111);
      out_ready = 1'b1;
      t = 0;
      while (!in_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      chk("bp_count", n_out - n0, 3);

      // sustained throughput
      n0 = n_out;
      c0 = cyc;
      for (int i = 0; i < 20; i++) send(3'(i % M));
      chk("tp_cycles", cyc - c0, 20);
      chk("tp_inflight", n_out - n0, 19);
      drain();
      chk("tp_count", n_out - n0, 20);

      // asynchronous reset while FULL
      out_ready = 1'b0;
      send(3'd7);
      send(3'd2);
      chk("pre_rst_full", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_out", {out_err, out_sel, out}, 0);
      chk("arst_sticky", sticky_err, 0);
      sbq.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", out_valid, 0);
      send(3'd4);
      chk("post_rst_out", out, 32'h44444444);
      drain();

`ifdef ALU_FLAGS_EN
      results[2] = 32'h80000000;
      send(3'd2);
      chk("flags_neg", flags, 2'b10);
      send(3'd0);
      chk("flags_zero", flags, 2'b01);
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
